// File: rtl/multi_function_unit.sv
`default_nettype none
// ============================================================================
// Module   : multi_function_unit
// Purpose  : Lane-parallel vector post-processing unit. Each valid input
//            vector receives one of: activation (ReLU / clamp), element-wise
//            add, element-wise multiply, or bypass. Operand B comes from
//            secondary_inp or from an internal vector register file (VRF).
//            Two-stage pipeline, one vector per cycle, no backpressure.
// Ports    : clk, reset (sync, active-high)
//            activation_type   0 = ReLU, 1 = clamp to [-ACT_CLAMP, ACT_CLAMP]
//            operation         00 act, 01 add, 10 mul, 11 bypass
//            in_data_available primary_inp valid strobe
//            vrf_addr_read / vrf_addr_write, vrf_read_enable, vrf_write_enable
//            primary_inp       operand A (lane i at [(i+1)*DWIDTH-1 : i*DWIDTH])
//            secondary_inp     operand B / VRF write data
//            out_data          result vector, out_data_available strobe
// Revision : 1.0 - initial release
// ============================================================================
module multi_function_unit #(
    parameter int DESIGN_SIZE = 10,
    parameter int DWIDTH      = 16,
    parameter int VRF_AWIDTH  = 10,
    parameter int ACT_CLAMP   = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          activation_type,
    input  logic [1:0]                    operation,
    input  logic                          in_data_available,
    input  logic [VRF_AWIDTH-1:0]         vrf_addr_read,
    input  logic [VRF_AWIDTH-1:0]         vrf_addr_write,
    input  logic                          vrf_read_enable,
    input  logic                          vrf_write_enable,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] primary_inp,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] secondary_inp,
    output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
    output logic                          out_data_available
);

    localparam int c_vec_w     = DESIGN_SIZE * DWIDTH;
    localparam int c_vrf_depth = 1 << VRF_AWIDTH;

    localparam logic [1:0] c_op_act    = 2'b00;
    localparam logic [1:0] c_op_add    = 2'b01;
    localparam logic [1:0] c_op_mul    = 2'b10;

    localparam logic signed [DWIDTH-1:0] c_clamp_pos = DWIDTH'(ACT_CLAMP);
    localparam logic signed [DWIDTH-1:0] c_clamp_neg = -c_clamp_pos;

    // VRF storage; intentionally not reset.
    logic [c_vec_w-1:0] r_vrf [0:c_vrf_depth-1];

    // Stage-1 registers
    logic               r_s1_valid;
    logic [c_vec_w-1:0] r_a;
    logic [c_vec_w-1:0] r_b;
    logic [1:0]         r_op;
    logic               r_act_type;
    logic               r_vre;
    logic [c_vec_w-1:0] r_vrf_rdata;

    logic [c_vec_w-1:0] w_result;

    always_ff @(posedge clk) begin
        if (vrf_write_enable) begin
            r_vrf[vrf_addr_write] <= secondary_inp;
        end
    end

    // Datapath capture. The VRF read uses non-blocking semantics, so a
    // same-cycle write to the same address is not yet visible: old data wins.
    always_ff @(posedge clk) begin
        if (in_data_available) begin
            r_a         <= primary_inp;
            r_b         <= secondary_inp;
            r_op        <= operation;
            r_act_type  <= activation_type;
            r_vre       <= vrf_read_enable;
            r_vrf_rdata <= r_vrf[vrf_addr_read];
        end
    end

    // Valid pipeline and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid         <= 1'b0;
            out_data_available <= 1'b0;
            out_data           <= '0;
        end else begin
            r_s1_valid         <= in_data_available;
            out_data_available <= r_s1_valid;
            if (r_s1_valid) begin
                out_data <= w_result;
            end
        end
    end

    generate
        for (genvar i = 0; i < DESIGN_SIZE; i++) begin : g_lane
            logic signed [DWIDTH-1:0]   w_a;
            logic signed [DWIDTH-1:0]   w_b;
            logic signed [DWIDTH-1:0]   w_res;
            logic        [2*DWIDTH-1:0] w_prod;

            assign w_a = r_a[i*DWIDTH +: DWIDTH];
            assign w_b = r_vre ? r_vrf_rdata[i*DWIDTH +: DWIDTH]
                               : r_b[i*DWIDTH +: DWIDTH];

            // Sign-extend explicitly so the low half of the full product
            // is the two's-complement result.
            assign w_prod = {{DWIDTH{w_a[DWIDTH-1]}}, w_a}
                          * {{DWIDTH{w_b[DWIDTH-1]}}, w_b};

            always_comb begin
                w_res = w_a;
                case (r_op)
                    c_op_act: begin
                        if (!r_act_type) begin
                            w_res = (w_a < 0) ? '0 : w_a;
                        end else if (w_a > c_clamp_pos) begin
                            w_res = c_clamp_pos;
                        end else if (w_a < c_clamp_neg) begin
                            w_res = c_clamp_neg;
                        end else begin
                            w_res = w_a;
                        end
                    end
                    c_op_add: w_res = w_a + w_b;
                    c_op_mul: w_res = w_prod[DWIDTH-1:0];
                    default:  w_res = w_a;
                endcase
            end

            assign w_result[i*DWIDTH +: DWIDTH] = w_res;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_function_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_function_unit
// Purpose  : Self-checking bench for multi_function_unit. A driver issues
//            directed and random vectors and queues the expected result and
//            arrival cycle; a monitor compares whenever out_data_available.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_function_unit;

    localparam int N  = 10;
    localparam int W  = 16;
    localparam int AW = 10;
    typedef logic [N*W-1:0] vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          activation_type;
    logic [1:0]    operation;
    logic          in_data_available;
    logic [AW-1:0] vrf_addr_read;
    logic [AW-1:0] vrf_addr_write;
    logic          vrf_read_enable;
    logic          vrf_write_enable;
    vec_t          primary_inp;
    vec_t          secondary_inp;
    vec_t          out_data;
    logic          out_data_available;

    multi_function_unit #(
        .DESIGN_SIZE(N), .DWIDTH(W), .VRF_AWIDTH(AW), .ACT_CLAMP(255)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .activation_type    (activation_type),
        .operation          (operation),
        .in_data_available  (in_data_available),
        .vrf_addr_read      (vrf_addr_read),
        .vrf_addr_write     (vrf_addr_write),
        .vrf_read_enable    (vrf_read_enable),
        .vrf_write_enable   (vrf_write_enable),
        .primary_inp        (primary_inp),
        .secondary_inp      (secondary_inp),
        .out_data           (out_data),
        .out_data_available (out_data_available)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   fails  = 0;
    vec_t exp_q[$];
    int   exp_cyc_q[$];
    vec_t model_vrf [0:(1<<AW)-1];
    bit   vrf_written [0:7];

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] lane_ref(input logic [1:0] op, input bit act,
                                              input int a, input int b);
        int r;
        case (op)
            2'b00: begin
                if (act == 1'b0) r = (a < 0) ? 0 : a;
                else if (a > 255) r = 255;
                else if (a < -255) r = -255;
                else r = a;
            end
            2'b01: r = a + b;
            2'b10: r = a * b;
            default: r = a;
        endcase
        return W'(r);
    endfunction

    function automatic int lane_of(input vec_t v, input int i);
        logic signed [W-1:0] s;
        s = v[i*W +: W];
        return int'(s);
    endfunction

    // v[0] is lane N-1 so tables read like the lane lists lanes 9..0
    function automatic vec_t pack_hi(input int v[N]);
        vec_t p;
        for (int i = 0; i < N; i++) p[i*W +: W] = W'(v[N-1-i]);
        return p;
    endfunction

    function automatic vec_t splat(input int x);
        vec_t p;
        for (int i = 0; i < N; i++) p[i*W +: W] = W'(x);
        return p;
    endfunction

    // ---------------- driver ----------------
    // Called just after a rising edge; inputs are captured on the next edge.
    task automatic drive(input bit valid, input logic [1:0] op, input bit act,
                         input vec_t a, input vec_t b, input bit vre, input int raddr,
                         input bit we, input int waddr, input bit expect_out,
                         input bit use_exp, input vec_t exp_v);
        vec_t e;
        vec_t bsrc;
        in_data_available = valid;
        operation         = op;
        activation_type   = act;
        primary_inp       = a;
        secondary_inp     = b;
        vrf_read_enable   = vre;
        vrf_addr_read     = AW'(raddr);
        vrf_write_enable  = we;
        vrf_addr_write    = AW'(waddr);
        if (valid && expect_out) begin
            if (use_exp) begin
                e = exp_v;
            end else begin
                bsrc = vre ? model_vrf[raddr] : b;   // read before the write below
                for (int i = 0; i < N; i++)
                    e[i*W +: W] = lane_ref(op, act, lane_of(a, i), lane_of(bsrc, i));
            end
            exp_q.push_back(e);
            exp_cyc_q.push_back(cyc + 2);
        end
        if (we) model_vrf[waddr] = b;
        @(posedge clk); #1;
        in_data_available = 1'b0;
        vrf_write_enable  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (out_data_available) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL spurious_output cyc=%0d got=%h required=no output", cyc, out_data);
            end else begin
                vec_t e;
                int   ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                if (out_data !== e || cyc != ec) begin
                    fails++;
                    $display("FAIL result cyc=%0d got=%h required=%h at cyc %0d", cyc, out_data, e, ec);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int   t_a[N], t_b[N], t_e[N];
    vec_t va, vb, ve, rnd_a, rnd_b;

    initial begin
        reset = 1'b1;
        in_data_available = 1'b0; operation = 2'b00; activation_type = 1'b0;
        primary_inp = '0; secondary_inp = '0;
        vrf_read_enable = 1'b0; vrf_write_enable = 1'b0;
        vrf_addr_read = '0; vrf_addr_write = '0;
        for (int i = 0; i < 8; i++) vrf_written[i] = 1'b0;
        idle(2);
        checks++;
        if (out_data !== '0 || out_data_available !== 1'b0) begin
            fails++;
            $display("FAIL reset_state got=%h/%b required=0/0", out_data, out_data_available);
        end
        reset = 1'b0;
        idle(1);

        // add with secondary operand
        t_a = '{20,3,370,56,3,3234,3,3,3,3};
        t_b = '{4,4,4,4,4,4,4,40,1,1};
        t_e = '{24,7,374,60,7,3238,7,43,4,4};
        va = pack_hi(t_a); vb = pack_hi(t_b); ve = pack_hi(t_e);
        drive(1, 2'b01, 0, va, vb, 0, 0, 0, 0, 1, 1, ve);
        idle(3);

        // multiply via VRF address 1
        drive(0, 2'b00, 0, '0, vb, 0, 0, 1, 1, 0, 0, '0);
        t_e = '{80,12,1480,224,12,12936,12,120,3,3};
        ve = pack_hi(t_e);
        drive(1, 2'b10, 0, va, splat(999), 1, 1, 0, 0, 1, 1, ve);
        idle(3);

        // wrap-around
        drive(1, 2'b01, 0, splat(32767), splat(1), 0, 0, 0, 0, 1, 1, splat(-32768));
        drive(1, 2'b10, 1, splat(300), splat(300), 0, 0, 0, 0, 1, 1, splat(24464));
        idle(3);

        // activation boundaries
        t_a = '{-5,0,7,300,-300,255,-255,256,-256,32767};
        va = pack_hi(t_a);
        t_e = '{0,0,7,300,0,255,0,256,0,32767};
        drive(1, 2'b00, 0, va, splat(77), 0, 0, 0, 0, 1, 1, pack_hi(t_e));
        t_e = '{-5,0,7,255,-255,255,-255,255,-255,255};
        drive(1, 2'b00, 1, va, splat(77), 0, 0, 0, 0, 1, 1, pack_hi(t_e));
        idle(3);

        // bypass streaming, 4 back-to-back
        for (int k = 0; k < 4; k++) begin
            rnd_a = {$urandom, $urandom, $urandom, $urandom, $urandom};
            drive(1, 2'b11, k[0], rnd_a, splat(k + 5), k[1], 1, 0, 0, 1, 1, rnd_a);
        end
        idle(3);

        // preload VRF 0..7, then read-before-write on address 2
        for (int k = 0; k < 8; k++) begin
            rnd_b = {$urandom, $urandom, $urandom, $urandom, $urandom};
            drive(0, 2'b00, 0, '0, rnd_b, 0, 0, 1, k, 0, 0, '0);
            vrf_written[k] = 1'b1;
        end
        rnd_a = {$urandom, $urandom, $urandom, $urandom, $urandom};
        rnd_b = {$urandom, $urandom, $urandom, $urandom, $urandom};
        drive(1, 2'b01, 0, rnd_a, rnd_b, 1, 2, 1, 2, 1, 0, '0);
        drive(1, 2'b01, 0, rnd_a, '0, 1, 2, 0, 0, 1, 0, '0);
        idle(3);

        // random traffic
        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 0) begin
                    rnd_a[i*W +: W] = W'($urandom_range(0, 65535));
                    rnd_b[i*W +: W] = W'($urandom_range(0, 65535));
                end else begin
                    rnd_a[i*W +: W] = W'(int'($urandom_range(0, 700)) - 350);
                    rnd_b[i*W +: W] = W'(int'($urandom_range(0, 40)) - 20);
                end
            end
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  rnd_a, rnd_b, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                  1'($urandom_range(0, 1)), $urandom_range(0, 7), 1, 0, '0);
        end
        idle(3);

        // reset the cycle after a valid input: result must be discarded
        drive(1, 2'b11, 0, splat(1234), '0, 0, 0, 0, 0, 0, 0, '0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(4);
        checks++;
        if (out_data !== '0 || out_data_available !== 1'b0) begin
            fails++;
            $display("FAIL midop_reset got=%h/%b required=0/0", out_data, out_data_available);
        end

        // bounded drain of outstanding expectations
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle(1);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain outstanding=%0d required=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
